ghostbus_host_arb: RTL and testbench

- Two-port arbiter that shares one ghostbus host port (addr/din/dout/we) between two independent host requesters, e.g. a JTAG bridge and a UART/Ethernet bridge.
- Sits between the host bridges and the top-level decoded ghostbus that reaches host-accessible registers and RAMs.
- Serialises transactions, enforces fixed read latency, and returns read data and a completion ack to the winning requester.

---
 rtl/ghostbus_host_arb.sv | 123 ++++++++++++
 tb/tb_ghostbus_host_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_host_arb.sv
// Two-requester arbiter sharing one ghostbus host port, with a fixed read latency of RD_LAT.
// Defining GHOSTBUS_ARB_FIXED_PRIO_EN makes h0 win every tie; otherwise ties alternate round robin.
module ghostbus_host_arb #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          h0_req,
  input  logic [AW-1:0] h0_addr,
  input  logic [DW-1:0] h0_wdata,
  input  logic          h0_we,
  output logic          h0_ack,
  output logic [DW-1:0] h0_rdata,
  input  logic          h1_req,
  input  logic [AW-1:0] h1_addr,
  input  logic [DW-1:0] h1_wdata,
  input  logic          h1_we,
  output logic          h1_ack,
  output logic [DW-1:0] h1_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_din,
  input  logic [DW-1:0] gb_dout,
  output logic          gb_we
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;   // last_grant; also selects the in-flight requester
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          win;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = 1'b0;

`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
    win = !h0_req;
`else
    win = (h0_req && h1_req) ? !grant_q : !h0_req;
`endif

    unique case (state_q)
      IDLE: begin
        if (h0_req || h1_req) begin
          grant_d = win;
          addr_d  = win ? h1_addr  : h0_addr;
          din_d   = win ? h1_wdata : h0_wdata;
          we_d    = win ? h1_we    : h0_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = 4'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Count zero marks cycle T+RD_LAT, the only cycle gb_dout is guaranteed valid.
        if (cnt_q == 4'd0) begin
          if (grant_q) rdata1_d = gb_dout;
          else         rdata0_d = gb_dout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes decode from state so reset removes them without waiting for a clock.
  assign gb_we    = (state_q == ISSUE) && we_q;
  assign h0_ack   = (state_q == DONE) && !grant_q;
  assign h1_ack   = (state_q == DONE) &&  grant_q;
  assign gb_addr  = addr_q;
  assign gb_din   = din_q;
  assign h0_rdata = rdata0_q;
  assign h1_rdata = rdata1_q;

endmodule

// File: tb/tb_ghostbus_host_arb.sv
// Directed bench for ghostbus_host_arb: scoreboard of expected completions, latency-aware bus model.
module tb_ghostbus_host_arb;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          h0_req, h0_we, h1_req, h1_we;
  logic [AW-1:0] h0_addr, h1_addr;
  logic [DW-1:0] h0_wdata, h1_wdata;
  logic          h0_ack, h1_ack, gb_we;
  logic [DW-1:0] h0_rdata, h1_rdata, gb_din, gb_dout;
  logic [AW-1:0] gb_addr;

  ghostbus_host_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .h0_req(h0_req), .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_we(h0_we),
    .h0_ack(h0_ack), .h0_rdata(h0_rdata),
    .h1_req(h1_req), .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_we(h1_we),
    .h1_ack(h1_ack), .h1_rdata(h1_rdata),
    .gb_addr(gb_addr), .gb_din(gb_din), .gb_dout(gb_dout), .gb_we(gb_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   cyc    = 0;
  logic prev_we = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] bus_data(input logic [AW-1:0] a);
    return (a == 24'h000100) ? 32'hDEADBEEF : {8'hC3, a};
  endfunction

  // Bus model: read data for an address appears RD_LAT cycles after it is driven.
  logic [AW-1:0] apipe [RD_LAT];
  always @(posedge clk) begin
    cyc++;
    apipe[0] <= gb_addr;
    for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign gb_dout = bus_data(apipe[RD_LAT-1]);

  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (h0_ack || h1_ack) begin
        check("ack_onehot", {63'd0, h0_ack & h1_ack}, 64'd0);
        if (sb.size() == 0) begin
          check("sb_unexpected_ack", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("ack_port", {63'd0, h1_ack}, {63'd0, mon_e.port});
          if (!mon_e.we)
            check("rdata", mon_e.port ? h1_rdata : h0_rdata, mon_e.rdata);
        end
      end
      if (gb_we) begin
        check("we_single_cycle", {63'd0, prev_we}, 64'd0);
        if (sb.size() > 0) begin
          check("wr_addr", gb_addr, sb[0].addr);
          check("wr_din", gb_din, sb[0].wdata);
          check("wr_is_write", {63'd0, sb[0].we}, 64'd1);
        end
      end
      prev_we = gb_we;
    end
  end

  task automatic push_exp(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = we ? '0 : bus_data(addr);
    sb.push_back(e);
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port) begin
      h1_req = req; h1_we = we; h1_addr = addr; h1_wdata = wdata;
    end else begin
      h0_req = req; h0_we = we; h0_addr = addr; h0_wdata = wdata;
    end
  endtask

  // One isolated transaction; checks cycles from request to ack.
  task automatic txn(input logic port, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input string tag);
    int  k;
    logic got;
    push_exp(port, we, addr, wdata);
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (port ? h1_ack : h0_ack) got = 1'b1;
      else check({tag, "_other_ack"}, {63'd0, port ? h0_ack : h1_ack}, 64'd0);
    end
    check({tag, "_latency"}, 64'(k), we ? 64'd2 : 64'(RD_LAT + 2));
    drive(port, 1'b0, we, addr, wdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gb_we"}, {63'd0, gb_we}, 64'd0);
    check({tag, "_acks"}, {62'd0, h1_ack, h0_ack}, 64'd0);
    check({tag, "_h0_rdata"}, h0_rdata, 64'd0);
    check({tag, "_h1_rdata"}, h1_rdata, 64'd0);
    check({tag, "_gb_addr"}, gb_addr, 64'd0);
    check({tag, "_gb_din"}, gb_din, 64'd0);
  endtask

  initial begin
    int k, n, last_ack;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single write from h0, then single read from h1.
    txn(1'b0, 1'b1, 24'h000010, 32'h00000042, "wr_h0");
    txn(1'b1, 1'b0, 24'h000100, 32'h0, "rd_h1");
    check("rd_h1_h0_rdata_kept", h0_rdata, 64'd0);

    // Requester inputs change mid-read; only the latched 0x20 read may reach the bus.
    push_exp(1'b0, 1'b0, 24'h000020, '0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 24'h000020, 32'h0);
    k = 0;
    while (!h0_ack && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 2) drive(1'b0, 1'b1, 1'b1, 24'h000030, 32'h11111111);
      check("chg_gb_addr", gb_addr, 64'h20);
      check("chg_gb_we", {63'd0, gb_we}, 64'd0);
    end
    check("chg_latency", 64'(k), 64'(RD_LAT + 2));
    drive(1'b0, 1'b0, 1'b0, 24'h000030, 32'h0);
    check("chg_h1_rdata_kept", h1_rdata, 64'hDEADBEEF);

    // Back-to-back writes with h0 holding req: one ack every 3 cycles.
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 24'h000050, 32'hA5A50050);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 24'h000050, 32'hA5A50050);
    n = 0; k = 0; last_ack = 0;
    while (n < 4 && k < 60) begin
      @(negedge clk);
      k++;
      if (h0_ack) begin
        if (n > 0) check("b2b_ack_spacing", 64'(cyc - last_ack), 64'd3);
        last_ack = cyc;
        n++;
      end
    end
    check("b2b_ack_count", 64'(n), 64'd4);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("hold_gb_addr", gb_addr, 64'h50);
    check("hold_gb_din", gb_din, 64'hA5A50050);
    check("wr_h0_rdata_kept", h0_rdata, 64'hC3000020);

    // Reset during the ISSUE cycle of a write removes gb_we without a clock edge.
    push_exp(1'b1, 1'b1, 24'h000077, 32'h77777777);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 24'h000077, 32'h77777777);
    @(negedge clk);
    check("rst_wr_we_before", {63'd0, gb_we}, 64'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_wr");
    sb.delete();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during WAIT of a read aborts it with no ack.
    push_exp(1'b0, 1'b0, 24'h000040, '0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 24'h000040, '0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_rd");
    sb.delete();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_rd_no_ack", {62'd0, h1_ack, h0_ack}, 64'd0);
    rst = 1'b0;

    // Continuous contention after reset: six grants in the expected order.
    for (int i = 0; i < 6; i++) begin
`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
      push_exp(1'b0, 1'b1, 24'h0000A0, 32'h000000A0);
`else
      if (i % 2 == 0) push_exp(1'b0, 1'b1, 24'h0000A0, 32'h000000A0);
      else            push_exp(1'b1, 1'b1, 24'h0000B1, 32'h000000B1);
`endif
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 24'h0000A0, 32'h000000A0);
    drive(1'b1, 1'b1, 1'b1, 24'h0000B1, 32'h000000B1);
    n = 0; k = 0;
    while (n < 6 && k < 80) begin
      @(negedge clk);
      k++;
      if (h0_ack || h1_ack) n++;
    end
    check("contend_ack_count", 64'(n), 64'd6);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("contend_h0_rdata", h0_rdata, 64'd0);
    check("contend_h1_rdata", h1_rdata, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
